// File: rtl/combat_referee.sv
// Match referee: hitbox/hurtbox overlap, one-hit-per-attack damage, hit-stun
// timers and the FIGHT -> KO -> OVER round state machine.
module combat_referee #(
    parameter int MAX_HP      = 100,
    parameter int DAMAGE      = 10,
    parameter int STUN_CYCLES = 30,
    parameter int KO_HOLD     = 120,
    parameter int HIT_STATE   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        restart,
    input  logic [3:0]  p1_state,
    input  logic [3:0]  p2_state,
    input  logic [39:0] p1_hitbox,
    input  logic [39:0] p1_hurtbox,
    input  logic [39:0] p2_hitbox,
    input  logic [39:0] p2_hurtbox,
    output logic [7:0]  p1_hp,
    output logic [7:0]  p2_hp,
    output logic        p1_hit,
    output logic        p2_hit,
    output logic        p1_stun,
    output logic        p2_stun,
    output logic [1:0]  match_state,
    output logic [1:0]  winner,
    output logic        freeze
);

    localparam int SW = (STUN_CYCLES > 1) ? $clog2(STUN_CYCLES + 1) : 1;
    localparam int HW = (KO_HOLD > 1) ? $clog2(KO_HOLD) : 1;

    localparam logic [7:0]    MAX_HP_C  = 8'(MAX_HP);
    localparam logic [7:0]    DAMAGE_C  = 8'(DAMAGE);
    localparam logic [3:0]    HIT_C     = 4'(HIT_STATE);
    localparam logic [SW-1:0] STUN_C    = SW'(STUN_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(KO_HOLD - 1);

    typedef enum logic [1:0] {
        ST_FIGHT = 2'd0,
        ST_KO    = 2'd1,
        ST_OVER  = 2'd2,
        ST_RSVD  = 2'd3
    } match_e;

    // Boxes may arrive with either corner first (right-facing hurtboxes have x1 > x2).
    function automatic logic axis_overlap(input logic [9:0] a1, input logic [9:0] a2,
                                          input logic [9:0] b1, input logic [9:0] b2);
        logic [9:0] a_lo, a_hi, b_lo, b_hi;
        a_lo = (a1 < a2) ? a1 : a2;
        a_hi = (a1 < a2) ? a2 : a1;
        b_lo = (b1 < b2) ? b1 : b2;
        b_hi = (b1 < b2) ? b2 : b1;
        return (a_lo <= b_hi) && (b_lo <= a_hi);
    endfunction

    function automatic logic box_overlap(input logic [39:0] a, input logic [39:0] b);
        return axis_overlap(a[39:30], a[29:20], b[39:30], b[29:20]) &&
               axis_overlap(a[19:10], a[9:0],   b[19:10], b[9:0]);
    endfunction

    function automatic logic [7:0] take_damage(input logic [7:0] hp);
        return (hp <= DAMAGE_C) ? 8'd0 : hp - DAMAGE_C;
    endfunction

    match_e        state_q, state_d;
    logic [7:0]    p1_hp_q, p1_hp_d, p2_hp_q, p2_hp_d;
    logic          p1_hit_q, p1_hit_d, p2_hit_q, p2_hit_d;
    logic          p1_stun_q, p1_stun_d, p2_stun_q, p2_stun_d;
    logic [SW-1:0] p1_stun_cnt_q, p1_stun_cnt_d, p2_stun_cnt_q, p2_stun_cnt_d;
    logic          p1_latch_q, p1_latch_d, p2_latch_q, p2_latch_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [1:0]    winner_q, winner_d;
    logic          freeze_q, freeze_d;
    logic          hit_on_p1_s, hit_on_p2_s;

    // Candidate hits: attacker in its live-hitbox state, overlapping, not yet landed.
    always_comb begin
        hit_on_p2_s = (p1_state == HIT_C) && box_overlap(p1_hitbox, p2_hurtbox) &&
                      !p1_latch_q && (state_q == ST_FIGHT);
        hit_on_p1_s = (p2_state == HIT_C) && box_overlap(p2_hitbox, p1_hurtbox) &&
                      !p2_latch_q && (state_q == ST_FIGHT);
    end

    // Next-state logic for health, stun, latches and the round FSM.
    always_comb begin
        state_d       = state_q;
        p1_hp_d       = p1_hp_q;
        p2_hp_d       = p2_hp_q;
        p1_hit_d      = 1'b0;
        p2_hit_d      = 1'b0;
        p1_stun_cnt_d = (p1_stun_cnt_q != '0) ? p1_stun_cnt_q - SW'(1) : '0;
        p2_stun_cnt_d = (p2_stun_cnt_q != '0) ? p2_stun_cnt_q - SW'(1) : '0;
        p1_latch_d    = p1_latch_q;
        p2_latch_d    = p2_latch_q;
        hold_d        = hold_q;
        winner_d      = winner_q;

        case (state_q)
            ST_FIGHT: begin
                if (hit_on_p1_s) begin
                    p1_hp_d       = take_damage(p1_hp_q);
                    p1_hit_d      = 1'b1;
                    p1_stun_cnt_d = STUN_C;
                end else begin
                    p1_hit_d = 1'b0;
                end
                if (hit_on_p2_s) begin
                    p2_hp_d       = take_damage(p2_hp_q);
                    p2_hit_d      = 1'b1;
                    p2_stun_cnt_d = STUN_C;
                end else begin
                    p2_hit_d = 1'b0;
                end
                p1_latch_d = (p1_state != HIT_C) ? 1'b0 : (p1_latch_q | hit_on_p2_s);
                p2_latch_d = (p2_state != HIT_C) ? 1'b0 : (p2_latch_q | hit_on_p1_s);
                if ((p1_hp_d == 8'd0) || (p2_hp_d == 8'd0)) begin
                    state_d = ST_KO;
                    hold_d  = '0;
                    case ({p1_hp_d == 8'd0, p2_hp_d == 8'd0})
                        2'b01:   winner_d = 2'd1;
                        2'b10:   winner_d = 2'd2;
                        2'b11:   winner_d = 2'd3;
                        default: winner_d = 2'd0;
                    endcase
                end else begin
                    state_d = ST_FIGHT;
                end
            end
            ST_KO: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = ST_OVER;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            ST_OVER: begin
                if (restart) begin
                    state_d       = ST_FIGHT;
                    p1_hp_d       = MAX_HP_C;
                    p2_hp_d       = MAX_HP_C;
                    p1_stun_cnt_d = '0;
                    p2_stun_cnt_d = '0;
                    p1_latch_d    = 1'b0;
                    p2_latch_d    = 1'b0;
                    hold_d        = '0;
                    winner_d      = 2'd0;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: begin
                state_d       = ST_FIGHT;
                p1_hp_d       = MAX_HP_C;
                p2_hp_d       = MAX_HP_C;
                p1_stun_cnt_d = '0;
                p2_stun_cnt_d = '0;
                p1_latch_d    = 1'b0;
                p2_latch_d    = 1'b0;
                hold_d        = '0;
                winner_d      = 2'd0;
            end
        endcase

        p1_stun_d = (p1_stun_cnt_d != '0);
        p2_stun_d = (p2_stun_cnt_d != '0);
        freeze_d  = (state_d != ST_FIGHT);
    end

    // State and output registers; rst is synchronous and active-low.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= ST_FIGHT;
            p1_hp_q       <= MAX_HP_C;
            p2_hp_q       <= MAX_HP_C;
            p1_hit_q      <= 1'b0;
            p2_hit_q      <= 1'b0;
            p1_stun_q     <= 1'b0;
            p2_stun_q     <= 1'b0;
            p1_stun_cnt_q <= '0;
            p2_stun_cnt_q <= '0;
            p1_latch_q    <= 1'b0;
            p2_latch_q    <= 1'b0;
            hold_q        <= '0;
            winner_q      <= 2'd0;
            freeze_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            p1_hp_q       <= p1_hp_d;
            p2_hp_q       <= p2_hp_d;
            p1_hit_q      <= p1_hit_d;
            p2_hit_q      <= p2_hit_d;
            p1_stun_q     <= p1_stun_d;
            p2_stun_q     <= p2_stun_d;
            p1_stun_cnt_q <= p1_stun_cnt_d;
            p2_stun_cnt_q <= p2_stun_cnt_d;
            p1_latch_q    <= p1_latch_d;
            p2_latch_q    <= p2_latch_d;
            hold_q        <= hold_d;
            winner_q      <= winner_d;
            freeze_q      <= freeze_d;
        end
    end

    assign p1_hp       = p1_hp_q;
    assign p2_hp       = p2_hp_q;
    assign p1_hit      = p1_hit_q;
    assign p2_hit      = p2_hit_q;
    assign p1_stun     = p1_stun_q;
    assign p2_stun     = p2_stun_q;
    assign match_state = state_q;
    assign winner      = winner_q;
    assign freeze      = freeze_q;

endmodule

// File: tb/tb_combat_referee.sv
// Directed bench for combat_referee: table of single-cycle vectors plus
// hand-written sequences for stun duration, KO hold, restart and reset.
module tb_combat_referee;

    logic        clk = 1'b0;
    logic        rst, restart;
    logic [3:0]  p1_state, p2_state;
    logic [39:0] p1_hitbox, p1_hurtbox, p2_hitbox, p2_hurtbox;
    logic [7:0]  p1_hp, p2_hp;
    logic        p1_hit, p2_hit, p1_stun, p2_stun, freeze;
    logic [1:0]  match_state, winner;

    int checks = 0;
    int errors = 0;

    combat_referee dut (
        .clk(clk), .rst(rst), .restart(restart),
        .p1_state(p1_state), .p2_state(p2_state),
        .p1_hitbox(p1_hitbox), .p1_hurtbox(p1_hurtbox),
        .p2_hitbox(p2_hitbox), .p2_hurtbox(p2_hurtbox),
        .p1_hp(p1_hp), .p2_hp(p2_hp), .p1_hit(p1_hit), .p2_hit(p2_hit),
        .p1_stun(p1_stun), .p2_stun(p2_stun), .match_state(match_state),
        .winner(winner), .freeze(freeze)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, restart;
        logic [3:0]  p1s, p2s;
        logic [39:0] p2hu, p2hb;
        int          e_p1hp, e_p2hp;
        logic        e_p1hit, e_p2hit, e_p1st, e_p2st;
        int          e_ms, e_win;
        logic        e_frz;
    } vec_t;

    vec_t vecs[14];
    logic [39:0] hu_far, hu_yoff, hu_touch, hb_far, hb_touch;

    function automatic logic [39:0] box(input int x1, input int x2, input int y1, input int y2);
        logic [9:0] a, b, c, d;
        a = x1[9:0]; b = x2[9:0]; c = y1[9:0]; d = y2[9:0];
        return {a, b, c, d};
    endfunction

    function automatic vec_t mkv(input logic r, input logic rs, input logic [3:0] s1,
                                 input logic [3:0] s2, input logic [39:0] hu, input logic [39:0] hb,
                                 input int hp1, input int hp2, input logic h1, input logic h2,
                                 input logic st1, input logic st2, input int ms, input int w,
                                 input logic f);
        vec_t v;
        v.rst = r; v.restart = rs; v.p1s = s1; v.p2s = s2; v.p2hu = hu; v.p2hb = hb;
        v.e_p1hp = hp1; v.e_p2hp = hp2; v.e_p1hit = h1; v.e_p2hit = h2;
        v.e_p1st = st1; v.e_p2st = st2; v.e_ms = ms; v.e_win = w; v.e_frz = f;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] s1, input logic [3:0] s2,
                         input logic [39:0] hu, input logic [39:0] hb);
        p1_state = s1; p2_state = s2; p2_hurtbox = hu; p2_hitbox = hb;
    endtask

    task automatic chk_all(input string tag, input int hp1, input int hp2, input logic h1,
                           input logic h2, input logic st1, input logic st2, input int ms,
                           input int w, input logic f);
        chk({tag, ":p1_hp"}, 32'(p1_hp), hp1);
        chk({tag, ":p2_hp"}, 32'(p2_hp), hp2);
        chk({tag, ":p1_hit"}, 32'(p1_hit), 32'(h1));
        chk({tag, ":p2_hit"}, 32'(p2_hit), 32'(h2));
        chk({tag, ":p1_stun"}, 32'(p1_stun), 32'(st1));
        chk({tag, ":p2_stun"}, 32'(p2_stun), 32'(st2));
        chk({tag, ":match_state"}, 32'(match_state), ms);
        chk({tag, ":winner"}, 32'(winner), w);
        chk({tag, ":freeze"}, 32'(freeze), 32'(f));
    endtask

    task automatic run_vec(input int i);
        rst = vecs[i].rst; restart = vecs[i].restart;
        drive(vecs[i].p1s, vecs[i].p2s, vecs[i].p2hu, vecs[i].p2hb);
        tick();
        chk_all($sformatf("v%0d", i), vecs[i].e_p1hp, vecs[i].e_p2hp, vecs[i].e_p1hit,
                vecs[i].e_p2hit, vecs[i].e_p1st, vecs[i].e_p2st, vecs[i].e_ms,
                vecs[i].e_win, vecs[i].e_frz);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int ko_bad;
        int ticks;

        p1_hitbox  = box(247, 323, 194, 227);
        p1_hurtbox = box(100, 180, 150, 330);
        hu_far     = box(506, 457, 170, 320);
        hu_yoff    = box(323, 274, 228, 320);
        hu_touch   = box(323, 274, 170, 320);
        hb_far     = box(450, 380, 200, 230);
        hb_touch   = box(250, 170, 200, 230);

        vecs[0]  = mkv(0, 0, 0, 0, hu_far,   hb_far,   100, 100, 0, 0, 0, 0, 0, 0, 0);
        vecs[1]  = mkv(1, 0, 4, 0, hu_far,   hb_far,   100, 100, 0, 0, 0, 0, 0, 0, 0);
        vecs[2]  = mkv(1, 0, 4, 0, hu_yoff,  hb_far,   100, 100, 0, 0, 0, 0, 0, 0, 0);
        vecs[3]  = mkv(1, 0, 0, 0, hu_touch, hb_far,   100, 100, 0, 0, 0, 0, 0, 0, 0);
        vecs[4]  = mkv(1, 0, 4, 0, hu_touch, hb_far,   100,  90, 0, 1, 0, 1, 0, 0, 0);
        vecs[5]  = mkv(1, 0, 4, 0, hu_touch, hb_far,   100,  90, 0, 0, 0, 1, 0, 0, 0);
        vecs[6]  = mkv(1, 0, 4, 0, hu_touch, hb_far,   100,  90, 0, 0, 0, 1, 0, 0, 0);
        vecs[7]  = mkv(1, 0, 4, 0, hu_touch, hb_far,   100,  90, 0, 0, 0, 1, 0, 0, 0);
        vecs[8]  = mkv(1, 0, 4, 0, hu_touch, hb_far,   100,  90, 0, 0, 0, 1, 0, 0, 0);
        vecs[9]  = mkv(1, 0, 5, 0, hu_touch, hb_far,   100,  90, 0, 0, 0, 1, 0, 0, 0);
        vecs[10] = mkv(1, 0, 4, 0, hu_touch, hb_far,   100,  80, 0, 1, 0, 1, 0, 0, 0);
        vecs[11] = mkv(1, 0, 0, 0, hu_far,   hb_far,   100,  80, 0, 0, 0, 1, 0, 0, 0);
        vecs[12] = mkv(1, 0, 4, 4, hu_touch, hb_touch,  90,  70, 1, 1, 1, 1, 0, 0, 0);
        vecs[13] = mkv(1, 0, 0, 0, hu_far,   hb_far,    90,  70, 0, 0, 1, 1, 0, 0, 0);

        rst = 1'b0; restart = 1'b0;
        drive(4'd0, 4'd0, hu_far, hb_far);
        tick();
        for (int i = 0; i < 10; i++) run_vec(i);

        // p2_stun was high for samples v4..v9 (6); 24 more make 30 total.
        drive(4'd0, 4'd0, hu_touch, hb_far);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (p2_stun) cnt++;
        end
        chk("stun_len", cnt, 24);
        chk("stun_end", 32'(p2_stun), 0);
        chk("stun_hp", 32'(p2_hp), 90);

        for (int i = 10; i < 14; i++) run_vec(i);

        // Seven more p1 hits take p2 from 70 to 0 (last one saturates at 10 -> 0).
        for (int k = 1; k <= 7; k++) begin
            drive(4'd4, 4'd0, hu_touch, hb_far);
            tick();
            chk($sformatf("ko_hit%0d", k), 32'(p2_hit), 1);
            chk($sformatf("ko_hp%0d", k), 32'(p2_hp), 70 - 10 * k);
            if (k < 7) begin
                drive(4'd0, 4'd0, hu_touch, hb_far);
                tick();
            end
        end
        chk("ko_state", 32'(match_state), 1);
        chk("ko_winner", 32'(winner), 1);
        chk("ko_freeze", 32'(freeze), 1);
        chk("ko_p1hp", 32'(p1_hp), 90);

        // Hold in KO with both players attacking and a restart pulse; nothing may change.
        drive(4'd4, 4'd4, hu_touch, hb_touch);
        ticks = 0; ko_bad = 0;
        while (match_state != 2'd2 && ticks < 200) begin
            restart = (ticks == 5);
            tick();
            ticks++;
            if (p1_hit || p2_hit || p1_hp != 8'd90 || p2_hp != 8'd0 || freeze != 1'b1) ko_bad++;
        end
        restart = 1'b0;
        chk("ko_hold_len", ticks, 120);
        chk("ko_frozen", ko_bad, 0);
        chk("over_stun1", 32'(p1_stun), 0);
        chk("over_stun2", 32'(p2_stun), 0);
        tick();
        chk_all("over", 90, 0, 0, 0, 0, 0, 2, 1, 1);

        restart = 1'b1;
        tick();
        restart = 1'b0;
        chk_all("restart", 100, 100, 0, 0, 0, 0, 0, 0, 0);
        drive(4'd4, 4'd0, hu_touch, hb_far);
        tick();
        chk("post_restart_hit", 32'(p2_hit), 1);
        chk("post_restart_hp", 32'(p2_hp), 90);

        // Seven trades leave p1 at 30, p2 at 20; two p1 hits then KO p2.
        for (int k = 1; k <= 7; k++) begin
            drive(4'd0, 4'd0, hu_far, hb_far);
            tick();
            drive(4'd4, 4'd4, hu_touch, hb_touch);
            tick();
            chk($sformatf("trade%0d_p1", k), 32'(p1_hp), 100 - 10 * k);
            chk($sformatf("trade%0d_p2", k), 32'(p2_hp), 90 - 10 * k);
        end
        for (int k = 1; k <= 2; k++) begin
            drive(4'd0, 4'd0, hu_far, hb_far);
            tick();
            drive(4'd4, 4'd0, hu_touch, hb_far);
            tick();
        end
        chk("ko2_state", 32'(match_state), 1);
        chk("ko2_p1hp", 32'(p1_hp), 30);
        chk("ko2_p2hp", 32'(p2_hp), 0);
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk_all("rst_ko", 100, 100, 0, 0, 0, 0, 0, 0, 0);
        drive(4'd0, 4'd0, hu_far, hb_far);
        tick();
        drive(4'd4, 4'd0, hu_touch, hb_far);
        tick();
        chk("rst_resume_hit", 32'(p2_hit), 1);
        chk("rst_resume_hp", 32'(p2_hp), 90);
        chk("rst_resume_state", 32'(match_state), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
